pcie_cfg_mgmt_responder: RTL

Responder for the PCIe configuration management port. It accepts cfg_mgmt read/write requests from the core-side requester and serves them from a small emulated configuration dword space. It returns cfg_mgmt_read_write_done after a programmable latency. It is used as a stand-in for the hard IP config interface in loopback builds and simulation benches of the DMA benchmark design.

---
 rtl/cfg_mgmt_if.sv | 29 ++
 rtl/pcie_cfg_mgmt_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_mgmt_if.sv
// Configuration management request/response bundle between a core-side
// requester (master) and the emulated config-space responder (slave).
interface cfg_mgmt_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int FUNC_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] cfg_mgmt_addr;
  logic [FUNC_WIDTH-1:0] cfg_mgmt_function_number;
  logic                  cfg_mgmt_write;
  logic [31:0]           cfg_mgmt_write_data;
  logic [3:0]            cfg_mgmt_byte_enable;
  logic                  cfg_mgmt_read;
  logic [31:0]           cfg_mgmt_read_data;
  logic                  cfg_mgmt_read_write_done;
  logic                  busy;
  logic                  err_protocol;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done, busy, err_protocol
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done, busy, err_protocol
  );
endinterface

// File: rtl/pcie_cfg_mgmt_responder.sv
// Emulated PCIe cfg_mgmt responder: serves read/write requests from a small
// dword register space and completes them after a fixed, programmable latency.
module pcie_cfg_mgmt_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          FUNC_WIDTH  = 8,
  parameter int          REG_COUNT   = 64,
  parameter int          ACK_LATENCY = 4,
  parameter logic [31:0] ID_VALUE    = 32'h903f10ee
) (
  input  logic         clk,
  input  logic         rst_n,
  cfg_mgmt_if.slave    cfg
);

  localparam int CNT_W = $clog2(ACK_LATENCY + 1);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [FUNC_WIDTH-1:0] func_r;
  logic [31:0]           wdata_r;
  logic [3:0]            be_r;
  logic                  op_write_r;
  logic [31:0]           regs_r [REG_COUNT];

  logic                  req_s;
  logic                  held_s;
  logic                  abort_s;
  logic [ADDR_WIDTH-1:0] dec_addr_s;
  logic [FUNC_WIDTH-1:0] dec_func_s;
  logic                  dec_write_s;
  logic [31:0]           rd_result_s;
  logic                  commit_s;

  logic                  done_nxt_s;
  logic [31:0]           rdata_nxt_s;
  logic                  busy_nxt_s;
  logic                  err_nxt_s;
  logic                  done_r;
  logic [31:0]           rdata_r;
  logic                  busy_r;
  logic                  err_r;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign req_s   = cfg.cfg_mgmt_read | cfg.cfg_mgmt_write;
  assign held_s  = op_write_r ? cfg.cfg_mgmt_write : cfg.cfg_mgmt_read;
  assign abort_s = (state_r == ST_WAIT) && !held_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (ACK_LATENCY == 1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!held_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_HOLD;
      ST_HOLD: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latch and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= CNT_W'(0);
      addr_r     <= {ADDR_WIDTH{1'b0}};
      func_r     <= {FUNC_WIDTH{1'b0}};
      wdata_r    <= 32'h0;
      be_r       <= 4'h0;
      op_write_r <= 1'b0;
    end else if (state_r == ST_IDLE && req_s) begin
      cnt_r      <= CNT_W'(ACK_LATENCY - 1);
      addr_r     <= cfg.cfg_mgmt_addr;
      func_r     <= cfg.cfg_mgmt_function_number;
      wdata_r    <= cfg.cfg_mgmt_write_data;
      be_r       <= cfg.cfg_mgmt_byte_enable;
      op_write_r <= cfg.cfg_mgmt_write;
    end else if (state_r == ST_WAIT && cnt_r != CNT_W'(0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // With a one-cycle latency the read result is formed while the request is
  // still on the inputs, so decode looks through to them in IDLE.
  assign dec_addr_s  = (state_r == ST_IDLE) ? cfg.cfg_mgmt_addr : addr_r;
  assign dec_func_s  = (state_r == ST_IDLE) ? cfg.cfg_mgmt_function_number : func_r;
  assign dec_write_s = (state_r == ST_IDLE) ? cfg.cfg_mgmt_write : op_write_r;

  // Read decode
  always_comb begin
    rd_result_s = 32'h0;
    if (dec_func_s != {FUNC_WIDTH{1'b0}}) begin
      rd_result_s = 32'hFFFF_FFFF;
    end else if ({1'b0, dec_addr_s} >= ADDR_LIMIT) begin
      rd_result_s = 32'h0;
    end else begin
      rd_result_s = regs_r[dec_addr_s[IDX_W-1:0]];
    end
  end

  // Write commit qualifier, evaluated on the latched request
  always_comb begin
    commit_s = 1'b0;
    if (state_r == ST_DONE && op_write_r && func_r == {FUNC_WIDTH{1'b0}} &&
        {1'b0, addr_r} < ADDR_LIMIT && addr_r != {ADDR_WIDTH{1'b0}}) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Register file; dword 0 holds the read-only ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= (i == 0) ? ID_VALUE : 32'h0;
      end
    end else if (commit_s) begin
      regs_r[addr_r[IDX_W-1:0]] <= merge_bytes(regs_r[addr_r[IDX_W-1:0]], wdata_r, be_r);
    end
  end

  // Output logic, computed from the next state so outputs can be registered
  always_comb begin
    done_nxt_s  = 1'b0;
    rdata_nxt_s = 32'h0;
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    err_nxt_s   = 1'b0;
    if (state_nxt_s == ST_DONE) begin
      done_nxt_s = 1'b1;
      if (dec_write_s) begin
        rdata_nxt_s = 32'h0;
      end else begin
        rdata_nxt_s = rd_result_s;
      end
    end else begin
      done_nxt_s  = 1'b0;
      rdata_nxt_s = 32'h0;
    end
    if (state_r == ST_IDLE && cfg.cfg_mgmt_read && cfg.cfg_mgmt_write) begin
      err_nxt_s = 1'b1;
    end else if (abort_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r  <= 1'b0;
      rdata_r <= 32'h0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r  <= done_nxt_s;
      rdata_r <= rdata_nxt_s;
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign cfg.cfg_mgmt_read_write_done = done_r;
  assign cfg.cfg_mgmt_read_data       = rdata_r;
  assign cfg.busy                     = busy_r;
  assign cfg.err_protocol             = err_r;

endmodule
